// File: rtl/tblink_rpc_invoke_dispatch_if.sv
// Bundles the request, BFM command, response and status signals of the invoke dispatch stage.
// Ports: req_* (requests from the invoke layer), bfm_* (command port and completion from the BFM),
//        rsp_* (tagged responses back to the invoke layer), timeout_cycles, fifo_count, busy, err_stray_done.
interface tblink_rpc_invoke_dispatch_if #(
   parameter int DEPTH   = 4,
   parameter int MID_W   = 8,
   parameter int PARAM_W = 64,
   parameter int TAG_W   = 4
);
   logic                   req_valid;
   logic                   req_ready;
   logic [TAG_W-1:0]       req_tag;
   logic [MID_W-1:0]       req_method;
   logic                   req_blocking;
   logic [PARAM_W-1:0]     req_params;

   logic                   bfm_valid;
   logic                   bfm_ready;
   logic [MID_W-1:0]       bfm_method;
   logic [PARAM_W-1:0]     bfm_params;
   logic                   bfm_done;
   logic [PARAM_W-1:0]     bfm_retval;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [TAG_W-1:0]       rsp_tag;
   logic [PARAM_W-1:0]     rsp_retval;
   logic [1:0]             rsp_status;

   logic [15:0]            timeout_cycles;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   busy;
   logic                   err_stray_done;

   // Environment side: invoke layer plus BFM.
   modport master (
      output req_valid, req_tag, req_method, req_blocking, req_params,
      output bfm_ready, bfm_done, bfm_retval,
      output rsp_ready, timeout_cycles,
      input  req_ready, bfm_valid, bfm_method, bfm_params,
      input  rsp_valid, rsp_tag, rsp_retval, rsp_status,
      input  fifo_count, busy, err_stray_done
   );

   // Dispatch side.
   modport slave (
      input  req_valid, req_tag, req_method, req_blocking, req_params,
      input  bfm_ready, bfm_done, bfm_retval,
      input  rsp_ready, timeout_cycles,
      output req_ready, bfm_valid, bfm_method, bfm_params,
      output rsp_valid, rsp_tag, rsp_retval, rsp_status,
      output fifo_count, busy, err_stray_done
   );
endinterface

// File: rtl/tblink_rpc_invoke_dispatch.sv
// Purpose: queue TBLink method invocations and issue them one at a time to a BFM command port,
//          returning exactly one tagged response per request (blocking calls wait for bfm_done or timeout).
// Latency: accept at N -> bfm_valid at N+2; non-blocking rsp at N+3; blocking rsp the cycle after bfm_done.
// Backpressure: req_ready = FIFO not full (no same-cycle bypass); command and response held until their handshakes.
// Ports: clock, reset (sync, active-high); bus (slave modport) carries req_*, bfm_*, rsp_*,
//        timeout_cycles, fifo_count, busy, err_stray_done.
module tblink_rpc_invoke_dispatch #(
   parameter int DEPTH   = 4,
   parameter int MID_W   = 8,
   parameter int PARAM_W = 64,
   parameter int TAG_W   = 4
) (
   input logic                         clock,
   input logic                         reset,
   tblink_rpc_invoke_dispatch_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_TIMEOUT = 2'd1;

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [MID_W-1:0]   method;
      logic               blocking;
      logic [PARAM_W-1:0] params;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;

   // Request FIFO
   req_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   req_t             head;
   logic             full;
   logic             push;
   logic             pop;

   // Call sequencing
   state_t           state;
   state_t           state_nxt;
   logic [15:0]      wait_cnt;
   logic             timeout_hit;
   logic             cmd_fire;

   logic [MID_W-1:0]   bfm_method_q;
   logic [PARAM_W-1:0] bfm_params_q;
   logic [TAG_W-1:0]   rsp_tag_q;
   logic [PARAM_W-1:0] rsp_retval_q;
   logic [1:0]         rsp_status_q;
   logic               err_stray_q;

   assign head     = mem[rd_ptr];
   assign full     = (count == CNT_W'(DEPTH));
   // Held low during reset so nothing is accepted into a FIFO that is being flushed.
   assign bus.req_ready = !reset && !full;
   assign push     = bus.req_valid && bus.req_ready;
   assign cmd_fire = (state == ISSUE) && bus.bfm_ready;
   // The head entry stays in the FIFO until the BFM takes it; its tag is needed at that moment.
   assign pop      = cmd_fire;

   // timeout_cycles is read live; 0 means wait forever.
   assign timeout_hit = (bus.timeout_cycles != 16'd0) &&
                        (wait_cnt == (bus.timeout_cycles - 16'd1));

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {bus.req_tag, bus.req_method, bus.req_blocking, bus.req_params};
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = ISSUE;
         ISSUE:   if (bus.bfm_ready) state_nxt = head.blocking ? WAIT : RSP;
         WAIT:    if (bus.bfm_done || timeout_hit) state_nxt = RSP;
         RSP:     if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bfm_method_q <= '0;
         bfm_params_q <= '0;
         rsp_tag_q    <= '0;
         rsp_retval_q <= '0;
         rsp_status_q <= ST_OK;
         wait_cnt     <= '0;
         err_stray_q  <= 1'b0;
      end else begin
         if ((state == IDLE) && (count != '0)) begin
            bfm_method_q <= head.method;
            bfm_params_q <= head.params;
         end
         // Non-blocking calls complete here with a zero return value.
         if (cmd_fire) begin
            rsp_tag_q    <= head.tag;
            rsp_retval_q <= '0;
            rsp_status_q <= ST_OK;
            wait_cnt     <= '0;
         end
         if (state == WAIT) begin
            if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
            // Completion takes priority over a timeout landing on the same cycle.
            if (bus.bfm_done) begin
               rsp_retval_q <= bus.bfm_retval;
               rsp_status_q <= ST_OK;
            end else if (timeout_hit) begin
               rsp_retval_q <= '0;
               rsp_status_q <= ST_TIMEOUT;
            end
         end
         if (bus.bfm_done && (state != WAIT)) err_stray_q <= 1'b1;
      end
   end

   assign bus.bfm_valid      = (state == ISSUE);
   assign bus.bfm_method     = bfm_method_q;
   assign bus.bfm_params     = bfm_params_q;
   assign bus.rsp_valid      = (state == RSP);
   assign bus.rsp_tag        = rsp_tag_q;
   assign bus.rsp_retval     = rsp_retval_q;
   assign bus.rsp_status     = rsp_status_q;
   assign bus.fifo_count     = count;
   assign bus.busy           = (state != IDLE) || (count != '0);
   assign bus.err_stray_done = err_stray_q;
endmodule

// File: doc/tblink_rpc_invoke_dispatch.md
Name: tblink_rpc_invoke_dispatch

Overview:
- RTL stage directly downstream of the TBLink SV/DPI invoke layer. It receives method-invocation requests (method id, packed params, blocking flag, call tag) from the endpoint-side transactor.
- Requests are queued in a FIFO and issued one at a time to a BFM-side command port.
- Blocking calls wait for BFM completion under a programmable timeout. Each request produces exactly one tagged response back to the invoke layer.

Parameters:
DEPTH, 4, request FIFO depth; power of 2, minimum 2
MID_W, 8, method-id width
PARAM_W, 64, packed parameter and return-value width
TAG_W, 4, call-tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request FIFO can accept
req_tag  in  TAG_W  caller call tag
req_method  in  MID_W  method id
req_blocking  in  1  1 = blocking call
req_params  in  PARAM_W  packed params
bfm_valid  out  1  command valid to BFM
bfm_ready  in  1  BFM accepts command
bfm_method  out  MID_W  issued method id
bfm_params  out  PARAM_W  issued params
bfm_done  in  1  1-cycle pulse: blocking call complete
bfm_retval  in  PARAM_W  return value, sampled with bfm_done
rsp_valid  out  1  response valid
rsp_ready  in  1  invoke layer accepts response
rsp_tag  out  TAG_W  tag of completed request
rsp_retval  out  PARAM_W  return value
rsp_status  out  2  0=OK, 1=TIMEOUT, 2/3 reserved
timeout_cycles  in  16  blocking-call timeout; 0 disables timeout
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
busy  out  1  FSM not IDLE, or FIFO non-empty
err_stray_done  out  1  sticky: bfm_done seen outside WAIT

Behaviour:
- Reset (synchronous, active-high): clock and reset as named above.
  - All outputs 0; FIFO empty; FSM enters IDLE.
  - req_ready is 0 while reset is high and 1 on the first cycle after.
  - A reset mid-operation drops any in-flight call and all queued requests. No response is emitted for them. err_stray_done clears.
- FIFO:
  - Push when req_valid && req_ready. req_ready = !full.
  - When full, req_ready stays 0 even if a pop occurs the same cycle (no bypass).
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RSP.
  - IDLE: if FIFO non-empty, load head into bfm_method/bfm_params and go to ISSUE next cycle.
  - ISSUE: bfm_valid=1, payload stable until bfm_valid && bfm_ready. On the handshake cycle:
    - pop FIFO and latch the head tag;
    - non-blocking: go to RSP with retval=0, status OK;
    - blocking: go to WAIT with wait counter cleared to 0.
    - bfm_valid drops the cycle after the handshake.
  - WAIT: counter increments each cycle, saturating at 0xFFFF.
    - bfm_done: capture bfm_retval, go to RSP with status OK.
    - Else if timeout_cycles!=0 and counter==timeout_cycles-1: go to RSP with retval 0, status TIMEOUT.
    - bfm_done and timeout in the same cycle: done wins, status OK.
  - RSP: rsp_valid=1, with tag/retval/status stable until rsp_ready. On the handshake go to IDLE; rsp_valid drops the next cycle.
- Latency:
  - Request accepted at cycle N with FIFO previously empty and FSM idle: bfm_valid first high at N+2.
  - Non-blocking with bfm_ready=1: rsp_valid at N+3.
  - Blocking: rsp_valid on the cycle after bfm_done.
- Only one call is outstanding at a time. Responses are in request order.
- bfm_done outside WAIT is ignored for FSM purposes and sets err_stray_done (sticky until reset).
- timeout_cycles is sampled live each WAIT cycle. Changing it mid-call takes effect immediately.
- busy = (state!=IDLE) || (fifo_count!=0).

Test Plan:
- Single non-blocking request: tag=3, method=0x12, params=0xDEAD, bfm_ready=1 -> bfm_valid at N+2 carrying 0x12/0xDEAD; rsp at N+3 with tag=3, retval=0, status=0.
- Blocking call: bfm_done pulsed 5 cycles after issue with retval=0x55AA -> rsp tag matches, retval=0x55AA, status=0; fifo_count=0; busy deasserts after rsp handshake.
- Timeout: timeout_cycles=8, no bfm_done -> rsp_status=1, retval=0, 8 cycles after entering WAIT. Also with bfm_done on the timeout cycle -> status=0.
- Backpressure/full (DEPTH=4): push 5 requests while bfm_ready=0:
  - req_ready low after the 4th accept; 5th held;
  - release bfm_ready and rsp_ready=1 -> 5 responses with tags in order; fifo_count never exceeds 4.
- rsp_ready held 0 for 10 cycles -> rsp fields stable, no further bfm_valid issued until the rsp handshake.
- Reset while in WAIT with 2 queued requests -> no responses; all outputs 0 after reset, fifo_count=0; a stray bfm_done afterwards sets err_stray_done=1.
